// File: rtl/dataint_parity_stream.sv
// Streaming per-chunk parity generator/checker with a one-deep valid/ready
// output register, sticky error flags, saturating error counter and first-error capture.
module dataint_parity_stream #(
  parameter int CHUNKS    = 4,
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_data,
  input  logic [CHUNKS-1:0]    i_parity,
  input  logic                 i_parity_type,
  input  logic                 i_check_en,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     o_data,
  output logic [CHUNKS-1:0]    o_parity,
  output logic [CHUNKS-1:0]    o_error,
  input  logic                 i_clear,
  output logic [CHUNKS-1:0]    o_err_sticky,
  output logic [CNT_WIDTH-1:0] o_err_count,
  output logic [CHUNKS-1:0]    o_first_err,
  output logic                 o_first_err_vld
);

  localparam int CS = WIDTH / CHUNKS;

  logic [CHUNKS-1:0]    w_raw;
  logic [CHUNKS-1:0]    w_par;
  logic [CHUNKS-1:0]    w_err;
  logic                 w_accept;
  logic                 w_any_err;

  logic                 r_valid;
  logic [WIDTH-1:0]     r_data;
  logic [CHUNKS-1:0]    r_par;
  logic [CHUNKS-1:0]    r_err;
  logic [CHUNKS-1:0]    r_sticky;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CHUNKS-1:0]    r_first;
  logic                 r_first_vld;

  // XOR reduction per chunk; the last chunk absorbs the remainder bits.
  for (genvar k = 0; k < CHUNKS; k++) begin : g_chunk
    localparam int LO = k * CS;
    localparam int HI = (k == CHUNKS - 1) ? WIDTH - 1 : (k + 1) * CS - 1;
    assign w_raw[k] = ^i_data[HI:LO];
  end

  assign w_par     = i_parity_type ? w_raw : ~w_raw;
  assign w_err     = i_check_en ? (w_par ^ i_parity) : '0;
  assign w_any_err = |w_err;
  assign o_ready   = ~r_valid | i_ready;
  assign w_accept  = i_valid & o_ready;

  // Output stage: load on accept, drain when downstream takes the beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_par   <= '0;
      r_err   <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_par   <= w_par;
      r_err   <= w_err;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Error statistics; a clear overrides any error in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sticky    <= '0;
      r_cnt       <= '0;
      r_first     <= '0;
      r_first_vld <= 1'b0;
    end else if (i_clear) begin
      r_sticky    <= '0;
      r_cnt       <= '0;
      r_first     <= '0;
      r_first_vld <= 1'b0;
    end else if (w_accept && w_any_err) begin
      r_sticky <= r_sticky | w_err;
      if (r_cnt != {CNT_WIDTH{1'b1}}) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      if (!r_first_vld) begin
        r_first     <= w_err;
        r_first_vld <= 1'b1;
      end
    end
  end

  assign o_valid         = r_valid;
  assign o_data          = r_data;
  assign o_parity        = r_par;
  assign o_error         = r_err;
  assign o_err_sticky    = r_sticky;
  assign o_err_count     = r_cnt;
  assign o_first_err     = r_first;
  assign o_first_err_vld = r_first_vld;

endmodule

// File: tb/tb_dataint_parity_stream.sv
// Bench for dataint_parity_stream: table vectors, directed corner sequences
// and a randomized run against a behavioural model.
module tb_dataint_parity_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 32 bits, 4 chunks, 16-bit counter
  logic        a_valid, a_oready, a_even, a_chk;
  logic        a_ovalid, a_iready, a_clear, a_fvld;
  logic [31:0] a_data, a_odata;
  logic [3:0]  a_pin, a_opar, a_oerr, a_sticky, a_first;
  logic [15:0] a_cnt;

  // Instance B: 10 bits, 3 chunks, 2-bit counter
  logic        b_valid, b_oready, b_even, b_chk;
  logic        b_ovalid, b_iready, b_clear, b_fvld;
  logic [9:0]  b_data, b_odata;
  logic [2:0]  b_pin, b_opar, b_oerr, b_sticky, b_first;
  logic [1:0]  b_cnt;

  dataint_parity_stream #(.CHUNKS(4), .WIDTH(32), .CNT_WIDTH(16)) u_a (
    .i_clk(clk), .i_rst(rst),
    .i_valid(a_valid), .o_ready(a_oready),
    .i_data(a_data), .i_parity(a_pin),
    .i_parity_type(a_even), .i_check_en(a_chk),
    .o_valid(a_ovalid), .i_ready(a_iready),
    .o_data(a_odata), .o_parity(a_opar), .o_error(a_oerr),
    .i_clear(a_clear), .o_err_sticky(a_sticky),
    .o_err_count(a_cnt), .o_first_err(a_first),
    .o_first_err_vld(a_fvld)
  );

  dataint_parity_stream #(.CHUNKS(3), .WIDTH(10), .CNT_WIDTH(2)) u_b (
    .i_clk(clk), .i_rst(rst),
    .i_valid(b_valid), .o_ready(b_oready),
    .i_data(b_data), .i_parity(b_pin),
    .i_parity_type(b_even), .i_check_en(b_chk),
    .o_valid(b_ovalid), .i_ready(b_iready),
    .o_data(b_odata), .o_parity(b_opar), .o_error(b_oerr),
    .i_clear(b_clear), .o_err_sticky(b_sticky),
    .o_err_count(b_cnt), .o_first_err(b_first),
    .o_first_err_vld(b_fvld)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  pin;
    logic        even;
    logic        chk;
    logic [3:0]  epar;
    logic [3:0]  eerr;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference parity: count ones in each byte lane, even/odd by rule.
  function automatic logic [3:0] ref_par(input logic [31:0] d,
                                         input logic even);
    logic [3:0] p;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] c;
      c = (d >> (8 * k)) & 32'hFF;
      p[k] = ($countones(c) % 2 == 1) ? even : !even;
    end
    return p;
  endfunction

  // Behavioural model state
  logic        m_v;
  logic [31:0] m_data;
  logic [3:0]  m_par, m_err, m_st, m_first;
  logic [15:0] m_cnt;
  logic        m_fv;

  initial begin
    vt[0] = '{32'h01030700, 4'h0, 1'b1, 1'b0, 4'b1010, 4'b0000};
    vt[1] = '{32'h000000FF, 4'b0001, 1'b0, 1'b1, 4'b1111, 4'b1110};
    vt[2] = '{32'hFFFFFFFF, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000};
    vt[3] = '{32'h80000001, 4'b0000, 1'b1, 1'b1, 4'b1001, 4'b1001};
    vt[4] = '{32'h00000000, 4'b1010, 1'b0, 1'b0, 4'b1111, 4'b0000};
    vt[5] = '{32'h12345678, 4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0000};

    rst = 1'b1;
    {a_valid, a_even, a_chk, a_iready, a_clear} = '0;
    a_data = '0; a_pin = '0;
    {b_valid, b_even, b_chk, b_iready, b_clear} = '0;
    b_data = '0; b_pin = '0;
    tick(); tick();

    chk("rst_a_valid", 64'(a_ovalid), 64'd0);
    chk("rst_a_ready", 64'(a_oready), 64'd1);
    chk("rst_a_cnt", 64'(a_cnt), 64'd0);
    chk("rst_a_fvld", 64'(a_fvld), 64'd0);
    chk("rst_b_valid", 64'(b_ovalid), 64'd0);
    rst = 1'b0;
    tick();

    // Table vectors, back-to-back at full throughput
    a_iready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1;
      a_data  = vt[i].data;
      a_pin   = vt[i].pin;
      a_even  = vt[i].even;
      a_chk   = vt[i].chk;
      tick();
      chk("tbl_valid", 64'(a_ovalid), 64'd1);
      chk("tbl_data", 64'(a_odata), 64'(vt[i].data));
      chk("tbl_par", 64'(a_opar), 64'(vt[i].epar));
      chk("tbl_err", 64'(a_oerr), 64'(vt[i].eerr));
    end
    a_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(a_ovalid), 64'd0);
    chk("tbl_sticky", 64'(a_sticky), 64'hF);
    chk("tbl_cnt", 64'(a_cnt), 64'd2);
    chk("tbl_first", 64'(a_first), 64'hE);
    chk("tbl_fvld", 64'(a_fvld), 64'd1);

    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    chk("clr_sticky", 64'(a_sticky), 64'd0);
    chk("clr_cnt", 64'(a_cnt), 64'd0);
    chk("clr_fvld", 64'(a_fvld), 64'd0);

    // Backpressure: beat A held for 3 stalled cycles while B waits
    a_chk = 1'b0; a_even = 1'b1;
    a_valid = 1'b1; a_data = 32'hA5A5_0001;
    tick();
    a_iready = 1'b0;
    a_data = 32'h0B0B_0002;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_oready", 64'(a_oready), 64'd0);
      tick();
      chk("bp_data", 64'(a_odata), 64'hA5A50001);
      chk("bp_par", 64'(a_opar), 64'(ref_par(32'hA5A50001, 1'b1)));
      chk("bp_valid", 64'(a_ovalid), 64'd1);
    end
    a_iready = 1'b1;
    #1;
    chk("bp_release", 64'(a_oready), 64'd1);
    tick();
    chk("bp_data_b", 64'(a_odata), 64'h0B0B0002);
    a_valid = 1'b0;
    tick();
    chk("bp_drain", 64'(a_ovalid), 64'd0);

    // Reset while stalled with an erroring beat held
    a_valid = 1'b1; a_data = 32'h0; a_chk = 1'b1; a_pin = 4'hF;
    tick();
    a_valid = 1'b0; a_iready = 1'b0;
    tick();
    chk("ms_valid", 64'(a_ovalid), 64'd1);
    chk("ms_cnt", 64'(a_cnt), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 64'(a_ovalid), 64'd0);
    chk("ar_ready", 64'(a_oready), 64'd1);
    chk("ar_cnt", 64'(a_cnt), 64'd0);
    chk("ar_sticky", 64'(a_sticky), 64'd0);
    chk("ar_err", 64'(a_oerr), 64'd0);
    chk("ar_fvld", 64'(a_fvld), 64'd0);
    #2 rst = 1'b0;
    a_iready = 1'b1;
    tick();
    chk("ar_lost", 64'(a_ovalid), 64'd0);

    // Saturation of a 2-bit counter, then clear on an erroring beat
    b_iready = 1'b1; b_chk = 1'b1; b_even = 1'b1;
    b_data = '0; b_pin = 3'b111; b_valid = 1'b1;
    repeat (5) tick();
    chk("sat_cnt", 64'(b_cnt), 64'd3);
    chk("sat_sticky", 64'(b_sticky), 64'h7);
    chk("sat_first", 64'(b_first), 64'h7);
    chk("sat_fvld", 64'(b_fvld), 64'd1);
    b_pin = 3'b001; b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    chk("sc_cnt", 64'(b_cnt), 64'd0);
    chk("sc_fvld", 64'(b_fvld), 64'd0);
    chk("sc_sticky", 64'(b_sticky), 64'd0);
    chk("sc_oerr", 64'(b_oerr), 64'h1);
    chk("sc_valid", 64'(b_ovalid), 64'd1);

    // Uneven 3/3/4-bit split
    b_data = 10'b11_0000_0001; b_chk = 1'b0; b_even = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("un_par", 64'(b_opar), 64'h1);
    chk("un_err", 64'(b_oerr), 64'h0);

    // Randomized run against the model
    a_valid = 1'b0; a_clear = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    m_v = 0; m_data = 0; m_par = 0; m_err = 0;
    m_st = 0; m_first = 0; m_cnt = 0; m_fv = 0;
    tick();
    for (int n = 0; n < 400; n++) begin
      logic acc;
      logic [3:0] p, e;
      a_valid  = ($urandom_range(0, 3) != 0);
      a_data   = $urandom;
      a_pin    = 4'($urandom);
      a_even   = 1'($urandom);
      a_chk    = 1'($urandom);
      a_iready = ($urandom_range(0, 3) != 0);
      a_clear  = ($urandom_range(0, 19) == 0);
      #1;
      chk("rnd_oready", 64'(a_oready), 64'(!m_v || a_iready));
      acc = a_valid && (!m_v || a_iready);
      p = ref_par(a_data, a_even);
      e = a_chk ? (p ^ a_pin) : 4'h0;
      if (a_clear) begin
        m_st = 0; m_cnt = 0; m_first = 0; m_fv = 0;
      end else if (acc && e != 0) begin
        m_st = m_st | e;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        if (!m_fv) begin
          m_first = e; m_fv = 1;
        end
      end
      if (acc) begin
        m_v = 1; m_data = a_data; m_par = p; m_err = e;
      end else if (a_iready) begin
        m_v = 0;
      end
      tick();
      chk("rnd_valid", 64'(a_ovalid), 64'(m_v));
      if (m_v) begin
        chk("rnd_data", 64'(a_odata), 64'(m_data));
        chk("rnd_par", 64'(a_opar), 64'(m_par));
        chk("rnd_err", 64'(a_oerr), 64'(m_err));
      end
      chk("rnd_sticky", 64'(a_sticky), 64'(m_st));
      chk("rnd_cnt", 64'(a_cnt), 64'(m_cnt));
      chk("rnd_first", 64'(a_first), 64'(m_first));
      chk("rnd_fvld", 64'(a_fvld), 64'(m_fv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
